// File: rtl/dbus_timer_pkg.sv
// Shared processor constants for the memory-mapped timer.
// Contents: default register byte addresses, the end of data-memory space,
// TCTL bit positions, the TCTL state struct and its bus read-back packing.
package dbus_timer_pkg;

    localparam logic [31:0] TIMER_ADDR_TCNT = 32'hF0000020;
    localparam logic [31:0] TIMER_ADDR_TLIM = 32'hF0000024;
    localparam logic [31:0] TIMER_ADDR_TCTL = 32'hF0000120;

    // Data memory occupies byte addresses below this value.
    localparam logic [31:0] DMEM_VALID = 32'h00000800;

    localparam int TCTL_READY   = 0;
    localparam int TCTL_OVERRUN = 2;
    localparam int TCTL_IE      = 8;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } tctl_t;

    // Bus view of TCTL: unused bits always read 0.
    function automatic logic [31:0] tctl_pack(input tctl_t c);
        logic [31:0] v;
        v               = '0;
        v[TCTL_READY]   = c.ready;
        v[TCTL_OVERRUN] = c.overrun;
        v[TCTL_IE]      = c.ie;
        return v;
    endfunction

endpackage

// File: rtl/dbus_timer_if.sv
// Shared data bus as seen by memory-mapped peripherals.
//   wren     : write strobe (shared with data memory)
//   addr     : byte address (shared with data memory)
//   dIn      : write data
//   dbus_out : peripheral read data, zero when the peripheral is not selected
//   intr     : level interrupt request
// master = CPU side, slave = peripheral side.
interface dbus_timer_if;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] dIn;
    logic [31:0] dbus_out;
    logic        intr;

    modport master (output wren, output addr, output dIn, input dbus_out, input intr);
    modport slave  (input wren, input addr, input dIn, output dbus_out, output intr);
endinterface

// File: rtl/dbus_timer_prescaler.sv
// timer_prescaler: free-running divider counting 0..PRESCALE-1.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : restart the count from 0 on the next edge
//   tick         : high for the single cycle in which the count is PRESCALE-1
module timer_prescaler #(
    parameter int PRESCALE = 10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dbus_timer.sv
// dbus_timer: memory-mapped interval timer on the shared data bus.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : slave side of dbus_timer_if (wren/addr/dIn in, dbus_out/intr out)
// Registers: TCNT (counter), TLIM (limit, 0 = free run), TCTL (IE/overrun/ready).
// TCNT advances once per PRESCALE clocks; reaching TLIM-1 wraps it to 0 and
// raises ready. intr = ready & IE.
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter logic [31:0] ADDR_TCNT = TIMER_ADDR_TCNT,
    parameter logic [31:0] ADDR_TLIM = TIMER_ADDR_TLIM,
    parameter logic [31:0] ADDR_TCTL = TIMER_ADDR_TCTL,
    parameter int          PRESCALE  = 10000
) (
    input  logic         clk,
    input  logic         reset_n,
    dbus_timer_if.slave  bus
);
    logic [31:0] tcnt, tlim;
    tctl_t       tctl;

    logic [31:0] tcnt_n;
    tctl_t       tctl_n;
    logic        tick, tick_eff, hit;
    logic        in_io, sel_cnt, sel_lim, sel_ctl;
    logic        wr_cnt, wr_lim, wr_ctl;

    // Register decode never claims data-memory space.
    assign in_io   = (bus.addr >= DMEM_VALID);
    assign sel_cnt = in_io && (bus.addr == ADDR_TCNT);
    assign sel_lim = in_io && (bus.addr == ADDR_TLIM);
    assign sel_ctl = in_io && (bus.addr == ADDR_TCTL);

    assign wr_cnt = bus.wren && sel_cnt;
    assign wr_lim = bus.wren && sel_lim;
    assign wr_ctl = bus.wren && sel_ctl;

    timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wr_cnt),
        .tick    (tick)
    );

    // A TCNT write swallows the coincident tick entirely (no count, no hit).
    assign tick_eff = tick && !wr_cnt;
    assign hit      = tick_eff && (tlim != 32'd0) && (tcnt == tlim - 32'd1);

    always_comb begin
        tcnt_n = tcnt;
        if (wr_cnt)
            tcnt_n = bus.dIn;
        else if (hit)
            tcnt_n = 32'd0;
        else if (tick_eff)
            tcnt_n = tcnt + 32'd1;
    end

    // Limit-hit sets win over a same-cycle software clear; writing 1 never sets.
    always_comb begin
        tctl_n = tctl;
        if (wr_ctl) begin
            tctl_n.ie      = bus.dIn[TCTL_IE];
            tctl_n.ready   = tctl.ready   & bus.dIn[TCTL_READY];
            tctl_n.overrun = tctl.overrun & bus.dIn[TCTL_OVERRUN];
        end
        if (hit) begin
            tctl_n.ready = 1'b1;
            if (tctl.ready)
                tctl_n.overrun = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt <= '0;
            tlim <= '0;
            tctl <= '0;
        end else begin
            tcnt <= tcnt_n;
            if (wr_lim)
                tlim <= bus.dIn;
            tctl <= tctl_n;
        end
    end

    always_comb begin
        bus.dbus_out = 32'd0;
        if (!bus.wren) begin
            if (sel_cnt)
                bus.dbus_out = tcnt;
            else if (sel_lim)
                bus.dbus_out = tlim;
            else if (sel_ctl)
                bus.dbus_out = tctl_pack(tctl);
        end
    end

    assign bus.intr = tctl.ready && tctl.ie;

endmodule

// File: tb/tb_dbus_timer.sv
// Directed self-checking bench for dbus_timer with PRESCALE=4.
// Inputs change 1ns after a rising edge; reads settle 1ns after the address
// is applied, so all sampling stays well clear of the clock edges.
module tb_dbus_timer;
    localparam logic [31:0] A_CNT = 32'hF0000020;
    localparam logic [31:0] A_LIM = 32'hF0000024;
    localparam logic [31:0] A_CTL = 32'hF0000120;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    dbus_timer_if bus ();

    dbus_timer #(
        .ADDR_TCNT (A_CNT),
        .ADDR_TLIM (A_LIM),
        .ADDR_TCTL (A_CTL),
        .PRESCALE  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.wren = 1'b0;
        bus.addr = a;
        #1;
        chk(tag, bus.dbus_out, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.dIn  = d;
        bus.wren = 1'b1;
        @(posedge clk);
        #1;
        bus.wren = 1'b0;
        bus.addr = 32'd0;
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.wren = 1'b0;
        bus.addr = 32'd0;
        bus.dIn  = 32'd0;
        step(2);
        rd("rst_tcnt", A_CNT, 32'd0);
        rd("rst_tlim", A_LIM, 32'd0);
        rd("rst_tctl", A_CTL, 32'd0);
        chk("rst_intr", {31'd0, bus.intr}, 32'd0);

        // Free run after release: TCNT advances on every 4th edge.
        reset_n = 1'b1;
        step(3);  rd("free_e3",  A_CNT, 32'd0);
        step(1);  rd("free_e4",  A_CNT, 32'd1);
        step(3);  rd("free_e7",  A_CNT, 32'd1);
        step(4);  rd("free_e11", A_CNT, 32'd2);
        chk("free_intr", {31'd0, bus.intr}, 32'd0);

        // TLIM=3, IE=1. TCNT write (W0) coincides with a tick: write wins.
        wr(A_CNT, 32'd0);            // W0, prescaler restarts
        rd("tcnt_over_tick", A_CNT, 32'd0);
        wr(A_LIM, 32'd3);            // W1
        wr(A_CTL, 32'h100);          // W2
        rd("tlim_rb", A_LIM, 32'd3);
        step(9);                     // W11
        rd("pre_hit_tcnt", A_CNT, 32'd2);
        chk("pre_hit_intr", {31'd0, bus.intr}, 32'd0);
        step(1);                     // W12: third tick -> hit
        rd("hit_tcnt", A_CNT, 32'd0);
        rd("hit_tctl", A_CTL, 32'h101);
        chk("hit_intr", {31'd0, bus.intr}, 32'd1);
        step(12);                    // W24: sixth tick -> overrun
        rd("ovr_tctl", A_CTL, 32'h105);

        // Software clear, then clear attempt colliding with a hit.
        wr(A_CTL, 32'h100);          // W25
        rd("clr_tctl", A_CTL, 32'h100);
        chk("clr_intr", {31'd0, bus.intr}, 32'd0);
        step(10);                    // W35
        wr(A_CTL, 32'h100);          // W36 = hit edge
        rd("clr_vs_hit_tctl", A_CTL, 32'h101);
        chk("clr_vs_hit_intr", {31'd0, bus.intr}, 32'd1);

        // Free-run wrap with TLIM=0.
        wr(A_LIM, 32'd0);            // W37
        wr(A_CNT, 32'hFFFF_FFFF);    // W38 = X0
        wr(A_CTL, 32'h100);          // X1, clear ready
        step(2);                     // X3
        rd("wrap_pre", A_CNT, 32'hFFFF_FFFF);
        step(1);                     // X4: tick
        rd("wrap_tcnt", A_CNT, 32'd0);
        rd("wrap_tctl", A_CTL, 32'h100);
        step(3);                     // X7, tick pending
        wr(A_CNT, 32'h1234);         // X8, write beats tick
        rd("wr_vs_tick", A_CNT, 32'h1234);
        step(3);                     // X11
        rd("pre_cleared", A_CNT, 32'h1234);
        step(1);                     // X12
        rd("pre_next", A_CNT, 32'h1235);

        // Decode: unselected addresses and writes read zero.
        rd("rd_dmem", 32'h0000_0100, 32'd0);
        rd("rd_gap",  32'hF000_0028, 32'd0);
        bus.addr = A_CNT; bus.dIn = 32'hDEAD_BEEF; bus.wren = 1'b1;
        #1;
        chk("rd_wren", bus.dbus_out, 32'd0);
        bus.wren = 1'b0;
        wr(A_LIM, 32'd5);            // TLIM below TCNT leaves TCNT alone
        rd("tlim_le_tcnt", A_CNT, 32'h1235);

        // Reset mid-count with ready=1 and a write in the reset cycle.
        wr(A_LIM, 32'd1);
        wr(A_CNT, 32'd0);            // V0
        wr(A_CTL, 32'h100);          // V1
        step(3);                     // V4: hit
        chk("pre_rst_intr", {31'd0, bus.intr}, 32'd1);
        step(1);
        reset_n = 1'b0;
        bus.addr = A_CNT; bus.dIn = 32'h55; bus.wren = 1'b1;
        step(1);
        bus.wren = 1'b0;
        reset_n = 1'b1;
        rd("post_rst_tcnt", A_CNT, 32'd0);
        rd("post_rst_tlim", A_LIM, 32'd0);
        rd("post_rst_tctl", A_CTL, 32'd0);
        chk("post_rst_intr", {31'd0, bus.intr}, 32'd0);
        step(3);
        rd("post_rst_e3", A_CNT, 32'd0);
        step(1);
        rd("post_rst_e4", A_CNT, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
